// File: rtl/ddr2_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_arb_pkg
// Shared definitions for the DDR2 local-port arbiter:
//   - arb_state_e : command-path FSM encoding (IDLE, WBURST)
//   - SIZE_MAX_W  : widest burst-size field the helpers handle
//   - size_norm() : burst size with 0 mapped to 1
//   - tag_w()     : width of a read tag entry {port id, size}
// ---------------------------------------------------------------------------
package ddr2_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } arb_state_e;

    // Burst sizes are carried through the helper at this width.
    // SIZE_W of the arbiter must not exceed it.
    localparam int SIZE_MAX_W = 8;

    // A burst size of 0 means a single beat.
    function automatic logic [SIZE_MAX_W-1:0] size_norm(input logic [SIZE_MAX_W-1:0] size);
        return (size == '0) ? SIZE_MAX_W'(1) : size;
    endfunction

    // Read tag entry layout is {port id, normalised size}.
    function automatic int tag_w(input int num_ports, input int size_w);
        return $clog2(num_ports) + size_w;
    endfunction

endpackage

// File: rtl/ddr2_arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// ddr2_arb_tag_fifo
// In-order FIFO of outstanding read tags. Full/empty are registered, so a
// push offered while full is dropped even if a pop happens in the same cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write an entry (ignored while full)
//   pop           discard the head entry (ignored while empty)
//   dout          head entry (valid while !empty)
//   full, empty   registered occupancy flags
// ---------------------------------------------------------------------------
module ddr2_arb_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (PTR_W + 1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // flags alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ddr2_local_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_local_port_arbiter
// Multi-port front end for the DDR2 controller local interface.
// Round-robin command selection (registered pointer, combinational
// pass-through), write bursts held atomically, read data routed back to the
// issuing port through an in-order tag FIFO with one cycle of latency.
// Ports:
//   phy_clk, reset_phy_clk          clock, synchronous active-high reset
//   p_*                             flattened client ports, slice i = port i
//   p_ready                         per-port command/beat accept
//   p_rdata, p_rdata_valid          registered read return (valid one-hot)
//   local_*  (out)                  controller command/write path
//   local_ready, local_init_done    controller handshake/status
//   local_rdata, local_rdata_valid  controller read return
//   rd_underflow                    sticky: read data with no tag outstanding
// ---------------------------------------------------------------------------
module ddr2_local_port_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int SIZE_W    = 3,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          phy_clk,
    input  logic                          reset_phy_clk,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_address,
    input  logic [NUM_PORTS-1:0]          p_read_req,
    input  logic [NUM_PORTS-1:0]          p_write_req,
    input  logic [NUM_PORTS-1:0]          p_burstbegin,
    input  logic [NUM_PORTS*SIZE_W-1:0]   p_size,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] p_be,
    output logic [NUM_PORTS-1:0]          p_ready,
    output logic [DATA_W-1:0]             p_rdata,
    output logic [NUM_PORTS-1:0]          p_rdata_valid,
    output logic [ADDR_W-1:0]             local_address,
    output logic [SIZE_W-1:0]             local_size,
    output logic [DATA_W-1:0]             local_wdata,
    output logic [DATA_W/8-1:0]           local_be,
    output logic                          local_read_req,
    output logic                          local_write_req,
    output logic                          local_burstbegin,
    input  logic                          local_ready,
    input  logic                          local_init_done,
    input  logic                          local_rdata_valid,
    input  logic [DATA_W-1:0]             local_rdata,
    output logic                          rd_underflow
);

    localparam int PID_W = $clog2(NUM_PORTS);
    localparam int BE_W  = DATA_W / 8;
    localparam int TAG_W = tag_w(NUM_PORTS, SIZE_W);

    arb_state_e       state, state_next;
    logic [PID_W-1:0] rr_ptr, rr_next;
    logic [PID_W-1:0] lock_port, lock_next;
    logic [SIZE_W-1:0] beats_left, beats_left_next;

    logic [PID_W-1:0]  grant;
    logic [PID_W-1:0]  cand;
    logic              found;
    logic              arb_en;
    logic              fwd_read;
    logic              fwd_write;
    logic              accept;
    logic [SIZE_W-1:0] sel_size;
    logic [SIZE_W-1:0] sel_size_n;

    logic              tag_full;
    logic              tag_empty;
    logic              tag_push;
    logic              tag_pop;
    logic [TAG_W-1:0]  tag_head;
    logic [PID_W-1:0]  head_port;
    logic [SIZE_W-1:0] head_size;
    logic [SIZE_W-1:0] rd_beats_done;

    // ---------------- round-robin selector ----------------
    // Offsets are scanned from the far end down so the nearest requester
    // to rr_ptr is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        grant = rr_ptr;
        cand  = rr_ptr;
        if (state == WBURST) begin
            grant = lock_port;
            found = p_write_req[lock_port];
        end else begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                cand = PID_W'((int'(rr_ptr) + k) % NUM_PORTS);
                if (p_read_req[cand] || p_write_req[cand]) begin
                    found = 1'b1;
                    grant = cand;
                end
            end
        end
    end

    // A port raising both strobes is treated as a write; reads are never
    // forwarded while a write burst holds the path.
    assign arb_en     = local_init_done && !reset_phy_clk;
    assign fwd_write  = arb_en && found && p_write_req[grant];
    assign fwd_read   = arb_en && found && (state == IDLE) &&
                        p_read_req[grant] && !p_write_req[grant];
    assign accept     = (fwd_write || fwd_read) && local_ready && !(fwd_read && tag_full);
    assign sel_size   = p_size[int'(grant)*SIZE_W +: SIZE_W];
    assign sel_size_n = SIZE_W'(size_norm(SIZE_MAX_W'(sel_size)));

    always_comb begin
        p_ready = '0;
        if (fwd_write || fwd_read) begin
            p_ready[grant] = local_ready && !(fwd_read && tag_full);
        end
    end

    assign local_address    = p_address[int'(grant)*ADDR_W +: ADDR_W];
    assign local_size       = sel_size;
    assign local_wdata      = p_wdata[int'(grant)*DATA_W +: DATA_W];
    assign local_be         = p_be[int'(grant)*BE_W +: BE_W];
    assign local_read_req   = fwd_read;
    assign local_write_req  = fwd_write;
    assign local_burstbegin = fwd_write && (state == IDLE) && p_burstbegin[grant];

    // ---------------- command FSM ----------------
    always_comb begin
        state_next      = state;
        rr_next         = rr_ptr;
        lock_next       = lock_port;
        beats_left_next = beats_left;
        if (accept) begin
            rr_next = (grant == PID_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
            case (state)
                IDLE: begin
                    if (fwd_write && (sel_size_n > SIZE_W'(1))) begin
                        beats_left_next = sel_size_n - 1'b1;
                        lock_next       = grant;
                        state_next      = WBURST;
                    end
                end
                WBURST: begin
                    beats_left_next = beats_left - 1'b1;
                    if (beats_left == SIZE_W'(1)) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset_phy_clk) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_port  <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_next;
            lock_port  <= lock_next;
            beats_left <= beats_left_next;
        end
    end

    // ---------------- read tag FIFO ----------------
    assign tag_push  = accept && fwd_read;
    assign head_port = tag_head[TAG_W-1 -: PID_W];
    assign head_size = tag_head[SIZE_W-1:0];
    // Beats are counted up against the stored size; the entry leaves the
    // FIFO on the beat that completes it.
    assign tag_pop   = local_rdata_valid && !tag_empty &&
                       ((rd_beats_done + SIZE_W'(1)) == head_size);

    ddr2_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk   (phy_clk),
        .rst   (reset_phy_clk),
        .push  (tag_push),
        .din   ({grant, sel_size_n}),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // ---------------- read return router ----------------
    always_ff @(posedge phy_clk) begin
        if (reset_phy_clk) begin
            p_rdata       <= '0;
            p_rdata_valid <= '0;
            rd_underflow  <= 1'b0;
            rd_beats_done <= '0;
        end else begin
            p_rdata_valid <= '0;
            if (local_rdata_valid) begin
                if (tag_empty) begin
                    rd_underflow <= 1'b1;
                end else begin
                    p_rdata_valid <= NUM_PORTS'(1) << head_port;
                    p_rdata       <= local_rdata;
                    rd_beats_done <= tag_pop ? '0 : rd_beats_done + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr2_local_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr2_local_port_arbiter
// Directed scenarios plus a randomized run, all compared each cycle against a
// queue-based behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_ddr2_local_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = 3;
    localparam int BW = DW / 8;
    localparam int TD = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  p_address;
    logic [NP-1:0]     p_read_req, p_write_req, p_burstbegin;
    logic [NP*SW-1:0]  p_size;
    logic [NP*DW-1:0]  p_wdata;
    logic [NP*BW-1:0]  p_be;
    logic [NP-1:0]     p_ready;
    logic [DW-1:0]     p_rdata;
    logic [NP-1:0]     p_rdata_valid;
    logic [AW-1:0]     local_address;
    logic [SW-1:0]     local_size;
    logic [DW-1:0]     local_wdata;
    logic [BW-1:0]     local_be;
    logic              local_read_req, local_write_req, local_burstbegin;
    logic              local_ready, local_init_done, local_rdata_valid;
    logic [DW-1:0]     local_rdata;
    logic              rd_underflow;

    ddr2_local_port_arbiter #(
        .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .SIZE_W (SW), .TAG_DEPTH (TD)
    ) dut (
        .phy_clk           (clk),
        .reset_phy_clk     (rst),
        .p_address         (p_address),
        .p_read_req        (p_read_req),
        .p_write_req       (p_write_req),
        .p_burstbegin      (p_burstbegin),
        .p_size            (p_size),
        .p_wdata           (p_wdata),
        .p_be              (p_be),
        .p_ready           (p_ready),
        .p_rdata           (p_rdata),
        .p_rdata_valid     (p_rdata_valid),
        .local_address     (local_address),
        .local_size        (local_size),
        .local_wdata       (local_wdata),
        .local_be          (local_be),
        .local_read_req    (local_read_req),
        .local_write_req   (local_write_req),
        .local_burstbegin  (local_burstbegin),
        .local_ready       (local_ready),
        .local_init_done   (local_init_done),
        .local_rdata_valid (local_rdata_valid),
        .local_rdata       (local_rdata),
        .rd_underflow      (rd_underflow)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // ---------------- behavioural model ----------------
    typedef struct { int port; int left; } tag_t;

    int            m_rr = 0;
    int            m_burst_left = 0;
    int            m_lock = 0;
    tag_t          m_tags[$];
    bit            m_underflow = 1'b0;
    logic [NP-1:0] m_rvalid = '0;
    logic [DW-1:0] m_rdata = '0;

    int            e_grant;
    bit            e_fwd_rd, e_fwd_wr, e_bb;
    logic [NP-1:0] e_ready;

    function automatic int norm(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic model_predict();
        e_ready  = '0;
        e_fwd_rd = 1'b0;
        e_fwd_wr = 1'b0;
        e_bb     = 1'b0;
        e_grant  = -1;
        if (!local_init_done || rst) return;
        if (m_burst_left > 0) begin
            if (p_write_req[m_lock]) begin
                e_grant  = m_lock;
                e_fwd_wr = 1'b1;
            end
        end else begin
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (m_rr + k) % NP;
                if (p_read_req[i] || p_write_req[i]) begin
                    e_grant = i;
                    break;
                end
            end
            if (e_grant >= 0) begin
                if (p_write_req[e_grant]) e_fwd_wr = 1'b1;
                else                      e_fwd_rd = 1'b1;
                e_bb = e_fwd_wr && p_burstbegin[e_grant];
            end
        end
        if (e_grant >= 0)
            e_ready[e_grant] = local_ready && !(e_fwd_rd && m_tags.size() >= TD);
    endtask

    task automatic model_update();
        tag_t h;
        int   sz;
        if (rst) begin
            m_rr = 0; m_burst_left = 0; m_lock = 0;
            m_tags.delete();
            m_underflow = 1'b0; m_rvalid = '0; m_rdata = '0;
            return;
        end
        // Return path sees the queue as it stood at the start of the cycle.
        m_rvalid = '0;
        if (local_rdata_valid) begin
            if (m_tags.size() == 0) begin
                m_underflow = 1'b1;
            end else begin
                h = m_tags[0];
                m_rvalid[h.port] = 1'b1;
                m_rdata = local_rdata;
                h.left--;
                if (h.left == 0) void'(m_tags.pop_front());
                else             m_tags[0] = h;
            end
        end
        if (e_grant >= 0 && e_ready[e_grant]) begin
            sz   = norm(int'(p_size[e_grant*SW +: SW]));
            m_rr = (e_grant + 1) % NP;
            if (e_fwd_rd) begin
                h.port = e_grant; h.left = sz;
                m_tags.push_back(h);
            end else if (m_burst_left > 0) begin
                m_burst_left--;
            end else if (sz > 1) begin
                m_burst_left = sz - 1;
                m_lock = e_grant;
            end
        end
    endtask

    // One clock cycle: inputs are already driven (just after a negedge).
    task automatic step(input string nm);
        #1;
        model_predict();
        total++;
        if (p_ready !== e_ready) $display("FAIL %s p_ready got %b exp %b", nm, p_ready, e_ready);
        else passed++;
        total++;
        if (local_read_req !== e_fwd_rd) $display("FAIL %s local_read_req got %b exp %b", nm, local_read_req, e_fwd_rd);
        else passed++;
        total++;
        if (local_write_req !== e_fwd_wr) $display("FAIL %s local_write_req got %b exp %b", nm, local_write_req, e_fwd_wr);
        else passed++;
        total++;
        if (local_burstbegin !== e_bb) $display("FAIL %s local_burstbegin got %b exp %b", nm, local_burstbegin, e_bb);
        else passed++;
        if (e_fwd_rd || e_fwd_wr) begin
            total++;
            if (local_address !== p_address[e_grant*AW +: AW] || local_size !== p_size[e_grant*SW +: SW])
                $display("FAIL %s addr/size got %h/%0d exp %h/%0d", nm, local_address, local_size,
                         p_address[e_grant*AW +: AW], p_size[e_grant*SW +: SW]);
            else passed++;
        end
        if (e_fwd_wr) begin
            total++;
            if (local_wdata !== p_wdata[e_grant*DW +: DW] || local_be !== p_be[e_grant*BW +: BW])
                $display("FAIL %s wdata/be got %h/%h exp %h/%h", nm, local_wdata, local_be,
                         p_wdata[e_grant*DW +: DW], p_be[e_grant*BW +: BW]);
            else passed++;
        end
        @(posedge clk);
        model_update();
        #1;
        total++;
        if (p_rdata_valid !== m_rvalid) $display("FAIL %s p_rdata_valid got %b exp %b", nm, p_rdata_valid, m_rvalid);
        else passed++;
        total++;
        if (rd_underflow !== m_underflow) $display("FAIL %s rd_underflow got %b exp %b", nm, rd_underflow, m_underflow);
        else passed++;
        if (m_rvalid != '0) begin
            total++;
            if (p_rdata !== m_rdata) $display("FAIL %s p_rdata got %h exp %h", nm, p_rdata, m_rdata);
            else passed++;
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        p_read_req = '0; p_write_req = '0; p_burstbegin = '0;
        local_ready = 1'b1; local_init_done = 1'b1; local_rdata_valid = 1'b0;
    endtask

    task automatic set_port(input int i, input bit rd, input bit wr, input bit bb, input int size);
        p_read_req[i]   = rd;
        p_write_req[i]  = wr;
        p_burstbegin[i] = bb;
        p_size[i*SW +: SW]    = SW'(size);
        p_address[i*AW +: AW] = AW'($urandom);
        p_wdata[i*DW +: DW]   = $urandom;
        p_be[i*BW +: BW]      = BW'($urandom);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        set_port(0, 0, 1, 1, 1);
        rst = 1'b1;
        #1;
        total++;
        if (p_ready !== 2'b00 || local_write_req !== 1'b0)
            $display("FAIL reset_gate p_ready/wr got %b/%b exp 00/0", p_ready, local_write_req);
        else passed++;
        step("reset");
        rst = 1'b0;
        total++;
        if (p_rdata_valid !== 2'b00 || rd_underflow !== 1'b0 || p_rdata !== '0)
            $display("FAIL reset_regs got %b/%b/%h exp 00/0/0", p_rdata_valid, rd_underflow, p_rdata);
        else passed++;
    endtask

    task automatic test_rr_alternate();
        logic [NP-1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_port(0, 0, 1, 1, 1);
            set_port(1, 0, 1, 1, 1);
            #1;
            total++;
            if (p_ready !== exp_seq[c]) $display("FAIL rr_alt[%0d] p_ready got %b exp %b", c, p_ready, exp_seq[c]);
            else passed++;
            step("rr_alt");
        end
    endtask

    task automatic test_write_burst();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c < 4) set_port(1, 0, 1, 1, 4);
            if (c > 0) set_port(0, 1, 0, 0, 1);
            #1;
            total++;
            if (p_ready !== ((c < 4) ? 2'b10 : 2'b01))
                $display("FAIL burst[%0d] p_ready got %b exp %b", c, p_ready, (c < 4) ? 2'b10 : 2'b01);
            else passed++;
            total++;
            if (local_burstbegin !== (c == 0))
                $display("FAIL burst[%0d] burstbegin got %b exp %b", c, local_burstbegin, c == 0);
            else passed++;
            step("burst");
        end
    endtask

    task automatic test_read_return();
        logic [NP-1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b01, 2'b10, 2'b10};
        do_reset();
        set_port(0, 1, 0, 1, 2);
        set_port(1, 1, 0, 1, 2);
        step("rd_issue");
        idle_inputs();
        set_port(1, 1, 0, 1, 2);
        step("rd_issue");
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            local_rdata_valid = 1'b1;
            local_rdata = $urandom;
            step("rd_ret");
            total++;
            if (p_rdata_valid !== exp_seq[c]) $display("FAIL rd_ret[%0d] valid got %b exp %b", c, p_rdata_valid, exp_seq[c]);
            else passed++;
        end
        local_rdata_valid = 1'b0;
        step("rd_ret_idle");
    endtask

    task automatic test_tag_full();
        do_reset();
        for (int c = 0; c < TD; c++) begin
            set_port(0, 1, 0, 1, 1);
            step("fill");
        end
        set_port(0, 1, 0, 1, 1);
        #1;
        total++;
        if (p_ready !== 2'b00) $display("FAIL full_block p_ready got %b exp 00", p_ready);
        else passed++;
        step("full");
        local_rdata_valid = 1'b1;
        local_rdata = $urandom;
        #1;
        total++;
        if (p_ready !== 2'b00) $display("FAIL full_pop_cycle p_ready got %b exp 00", p_ready);
        else passed++;
        step("full_pop");
        local_rdata_valid = 1'b0;
        #1;
        total++;
        if (p_ready !== 2'b01) $display("FAIL full_after_pop p_ready got %b exp 01", p_ready);
        else passed++;
        step("full_after");
        idle_inputs();
        local_rdata_valid = 1'b1;
        for (int c = 0; c < TD; c++) step("drain");
        local_rdata_valid = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        local_rdata_valid = 1'b1;
        step("uflow");
        total++;
        if (rd_underflow !== 1'b1 || p_rdata_valid !== 2'b00)
            $display("FAIL uflow got %b/%b exp 1/00", rd_underflow, p_rdata_valid);
        else passed++;
        local_rdata_valid = 1'b0;
        for (int c = 0; c < 3; c++) step("uflow_hold");
        total++;
        if (rd_underflow !== 1'b1) $display("FAIL uflow_sticky got %b exp 1", rd_underflow);
        else passed++;
        do_reset();
        total++;
        if (rd_underflow !== 1'b0) $display("FAIL uflow_clear got %b exp 0", rd_underflow);
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_port(1, 0, 1, 1, 4);
        step("mid_b1");
        set_port(1, 0, 1, 0, 4);
        rst = 1'b1;
        #1;
        total++;
        if (p_ready !== 2'b00) $display("FAIL mid_rst p_ready got %b exp 00", p_ready);
        else passed++;
        step("mid_rst");
        rst = 1'b0;
        idle_inputs();
        #1;
        total++;
        if (p_ready !== 2'b00 || local_write_req !== 1'b0)
            $display("FAIL mid_after p_ready/wr got %b/%b exp 00/0", p_ready, local_write_req);
        else passed++;
        step("mid_after");
        set_port(0, 1, 0, 1, 1);
        #1;
        total++;
        if (p_ready !== 2'b01 || local_read_req !== 1'b1)
            $display("FAIL mid_idle_read p_ready/rd got %b/%b exp 01/1", p_ready, local_read_req);
        else passed++;
        step("mid_read");
        idle_inputs();
        local_rdata_valid = 1'b1;
        step("mid_drain");
        local_rdata_valid = 1'b0;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst               = ($urandom_range(0, 99) == 0);
            local_init_done   = ($urandom_range(0, 9) != 0);
            local_ready       = ($urandom_range(0, 3) != 0);
            local_rdata_valid = ($urandom_range(0, 2) == 0);
            local_rdata       = $urandom;
            for (int i = 0; i < NP; i++) begin
                r = int'($urandom_range(0, 3));
                set_port(i, r == 1, r == 2, $urandom_range(0, 1) == 1, int'($urandom_range(0, 4)));
            end
            step("random");
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        p_address = '0; p_size = '0; p_wdata = '0; p_be = '0;
        local_rdata = '0;
        idle_inputs();
        test_reset();
        test_rr_alternate();
        test_write_burst();
        test_read_return();
        test_tag_full();
        test_underflow();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
